// File: rtl/riscv_pkg.sv
// Shared RV32M definitions for the multiply/divide unit and its users.
// Provides the default XLEN, the M-extension funct3 encodings, the FSM
// state encoding and the special-case result constants used for
// divide-by-zero and signed-overflow results.
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  // funct3 encodings of the M-extension (OP opcode, funct7 = 0000001)
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } md_state_t;

  localparam logic [XLEN_DEF-1:0] ALL_ONES = {XLEN_DEF{1'b1}};
  localparam logic [XLEN_DEF-1:0] INT_MIN  = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide operate on operand
// magnitudes, one bit per clock, followed by a sign fix in FIN.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   start  - op request, sampled only while idle
//   abort  - kill in-flight op, no done is produced
//   funct3 - op select (MUL..REMU)
//   rs1    - operand A (multiplicand / dividend)
//   rs2    - operand B (multiplier / divisor)
//   busy   - high while an op is in CALC or FIN
//   done   - one-cycle pulse, result valid in that cycle
//   result - registered result, held until the next done
module rv_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_ITER  = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] L_ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] L_INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] f_neg_x(input logic [XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] f_neg_w(input logic [2*XLEN-1:0] v, input logic n);
    return n ? (~v + 1'b1) : v;
  endfunction

  md_state_t         r_state, w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [2:0]        r_f3;
  logic              r_neg1, r_neg2;   // effective (signed-and-negative) operand signs
  logic              r_special;        // preset result, no sign correction
  logic [XLEN-1:0]   r_opb;            // multiplicand or divisor magnitude
  // Multiply: {partial product high, multiplier/product low}.
  // Divide:   {remainder, dividend shifting into quotient}.
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;
  logic              r_done;

  logic              w_sgn1, w_sgn2, w_neg1, w_neg2;
  logic [XLEN-1:0]   w_mag1, w_mag2;
  logic              w_div0, w_ovf, w_special;
  logic              w_accept, w_commit;
  logic [XLEN:0]     w_mul_sum, w_div_sh, w_div_diff;
  logic [2*XLEN-1:0] w_mul_nxt, w_div_nxt, w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_fin_val;

  // Operand decode for the request presented in IDLE
  assign w_sgn1 = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                  (funct3 == F3_DIV)  || (funct3 == F3_REM);
  assign w_sgn2 = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
  assign w_neg1 = w_sgn1 & rs1[XLEN-1];
  assign w_neg2 = w_sgn2 & rs2[XLEN-1];
  assign w_mag1 = f_neg_x(rs1, w_neg1);
  assign w_mag2 = f_neg_x(rs2, w_neg2);

  assign w_div0    = funct3[2] && (rs2 == '0);
  assign w_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                     (rs1 == L_INT_MIN) && (rs2 == L_ALL_ONES);
  assign w_special = w_div0 | w_ovf;

  // abort has priority over a simultaneous start
  assign w_accept = (r_state == ST_IDLE) && start && !abort;
  assign w_commit = (r_state == ST_FIN) && !abort;

  // One shift-add step: carry out of the add becomes the new product MSB
  assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

  // One restoring-divide step; the remainder stays below the divisor, so
  // the shifted value fits in XLEN+1 bits and bit XLEN of the difference
  // is the borrow.
  assign w_div_sh   = r_acc[2*XLEN-1:XLEN-1];
  assign w_div_diff = w_div_sh - {1'b0, r_opb};
  assign w_div_nxt  = w_div_diff[XLEN] ? {w_div_sh[XLEN-1:0],   r_acc[XLEN-2:0], 1'b0}
                                       : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

  // Sign correction and result select
  assign w_prod_fix = f_neg_w(r_acc, (r_neg1 ^ r_neg2) & ~r_special);
  assign w_quo_fix  = f_neg_x(r_acc[XLEN-1:0],
                              (r_f3 == F3_DIV) & (r_neg1 ^ r_neg2) & ~r_special);
  assign w_rem_fix  = f_neg_x(r_acc[2*XLEN-1:XLEN],
                              (r_f3 == F3_REM) & r_neg1 & ~r_special);

  always_comb begin
    w_fin_val = '0;
    case (r_f3)
      F3_MUL:                      w_fin_val = w_prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: w_fin_val = w_prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             w_fin_val = w_quo_fix;
      default:                     w_fin_val = w_rem_fix;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = w_special ? ST_FIN : ST_CALC;
      ST_CALC: begin
        if (abort)                   w_state_nxt = ST_IDLE;
        else if (r_cnt == LAST_ITER) w_state_nxt = ST_FIN;
      end
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_f3      <= '0;
      r_neg1    <= 1'b0;
      r_neg2    <= 1'b0;
      r_special <= 1'b0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_cnt     <= '0;
        r_f3      <= funct3;
        r_neg1    <= w_neg1;
        r_neg2    <= w_neg2;
        r_special <= w_special;
        if (w_div0) begin
          r_acc <= {rs1, L_ALL_ONES};
          r_opb <= '0;
        end else if (w_ovf) begin
          r_acc <= {{XLEN{1'b0}}, L_INT_MIN};
          r_opb <= '0;
        end else if (funct3[2]) begin
          r_acc <= {{XLEN{1'b0}}, w_mag1};
          r_opb <= w_mag2;
        end else begin
          r_acc <= {{XLEN{1'b0}}, w_mag2};
          r_opb <= w_mag1;
        end
      end else if ((r_state == ST_CALC) && !abort) begin
        r_acc <= r_f3[2] ? w_div_nxt : w_mul_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_commit) begin
        r_result <= w_fin_val;
        r_done   <= 1'b1;
      end
    end
  end

  assign busy   = (r_state != ST_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
module tb_rv_muldiv_unit;

  localparam int XLEN = 32;
  localparam int NV   = 16;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[NV];

  rv_muldiv_unit #(.XLEN(XLEN)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .funct3 (funct3),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Present a request now; it is sampled by the next rising edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Called just after the sampling edge; lat counts edges including that one.
  task automatic wait_done(output logic [31:0] res, output int lat, output bit bz_ok);
    lat   = 1;
    bz_ok = 1'b1;
    while (!done && lat < 60) begin
      if (!busy) bz_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) bz_ok = 1'b0;
    res = result;
  endtask

  initial begin
    logic [31:0] res;
    int          lat;
    bit          bz;
    int          seen;

    vecs[0]  = '{"mul_7_m3",       3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
    vecs[1]  = '{"mulh_min_min",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vecs[2]  = '{"mulhu_max_max",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vecs[3]  = '{"mulhsu_m1_2",    3'd2, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[4]  = '{"mulhsu_2_umax",  3'd2, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 34};
    vecs[5]  = '{"mulh_m3_7",      3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 34};
    vecs[6]  = '{"div_m7_2",       3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34};
    vecs[7]  = '{"rem_m7_2",       3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34};
    vecs[8]  = '{"div_7_m2",       3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
    vecs[9]  = '{"rem_7_m2",       3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34};
    vecs[10] = '{"divu_100_7",     3'd5, 32'd100,       32'd7,         32'd14,        34};
    vecs[11] = '{"remu_100_7",     3'd7, 32'd100,       32'd7,         32'd2,         34};
    vecs[12] = '{"divu_by0",       3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 2};
    vecs[13] = '{"div_ovf",        3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2};
    vecs[14] = '{"rem_ovf",        3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2};
    vecs[15] = '{"rem_by0",        3'd6, 32'd5,         32'd0,         32'd5,         2};

    reset  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    funct3 = '0;
    rs1    = '0;
    rs2    = '0;
    #1;
    check("reset_busy",   {31'd0, busy}, 32'd0);
    check("reset_done",   {31'd0, done}, 32'd0);
    check("reset_result", result,        32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Table-driven ops
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      issue(vecs[i].f3, vecs[i].a, vecs[i].b);
      wait_done(res, lat, bz);
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
      check({vecs[i].name, "_busy"}, {31'd0, bz}, 32'd1);
      @(posedge clk); #1;
      check({vecs[i].name, "_done_pulse"}, {31'd0, done}, 32'd0);
    end

    // Abort at CALC iteration 10: no done, result keeps previous value
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_result_held", result, vecs[NV-1].exp);

    // abort together with start in IDLE: nothing accepted
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy", {31'd0, busy}, 32'd0);

    // start while busy is ignored, including operand changes
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; funct3 = 3'd0; rs1 = 32'd3; rs2 = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(res, lat, bz);
    check("busy_start_result", res, 32'd14);
    check("busy_start_latency", lat + 6, 34);

    // Asynchronous reset at iteration 20
    @(negedge clk);
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("mid_reset_busy",   {31'd0, busy}, 32'd0);
    check("mid_reset_done",   {31'd0, done}, 32'd0);
    check("mid_reset_result", result,        32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("mid_reset_quiet", seen, 0);

    // Back-to-back: new start presented in the done cycle
    @(negedge clk);
    issue(3'd5, 32'd100, 32'd7);
    wait_done(res, lat, bz);
    check("b2b_first_result", res, 32'd14);
    issue(3'd7, 32'd100, 32'd7);
    wait_done(res, lat, bz);
    check("b2b_second_result", res, 32'd2);
    check("b2b_second_latency", lat, 34);
    check("b2b_second_busy", {31'd0, bz}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_unit.md
Name: rv_muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit. It sits downstream of the unicycle core's decode/register-read stage.
- The core stalls its PC while busy is high. It writes result to rd on the done pulse.
- Implements MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU with a start/busy/done handshake.
- Uses a radix-2 shift-add multiply and a restoring divide on operand magnitudes, followed by a sign fix.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (reset=0 clears all state immediately)
start  input  1  request; sampled only when busy=0
abort  input  1  kill in-flight op (core flush); no done generated
funct3  input  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
rs1  input  XLEN  operand A (dividend/multiplicand)
rs2  input  XLEN  operand B (divisor/multiplier)
busy  output  1  high from the cycle after start acceptance until the done cycle (exclusive)
done  output  1  one-cycle pulse; result valid in that cycle
result  output  XLEN  registered result, held until the next done

Behaviour:
- Reset (reset=0, async) values:
  - State IDLE.
  - busy=0, done=0, result=0.
  - Iteration counter 0, accumulators 0.
- States are IDLE, CALC, FIN.
- IDLE, start=1:
  - Latch funct3 and operand magnitudes.
  - Latch sign flags:
    - rs1 signed for MULH, MULHSU, DIV, REM.
    - rs2 signed for MULH, DIV, REM.
  - Special cases go straight to FIN with a preset result:
    - Divide by zero (rs2=0, funct3 4-7): quotient all-ones; remainder = rs1 unmodified.
    - Signed overflow (DIV/REM with rs1=0x80000000, rs2=0xFFFFFFFF): quotient 0x80000000; remainder 0.
  - Otherwise go to CALC with counter=0.
- CALC:
  - One iteration per clock.
  - Multiply: 2*XLEN product register; add multiplicand when the multiplier LSB is 1, then shift.
  - Divide: shift remainder:quotient left by 1, trial-subtract the divisor, keep the result if non-negative and set the quotient LSB.
  - At counter=XLEN-1, go to FIN.
- FIN:
  - Negate the 2*XLEN product if the effective signs differ.
  - Negate the quotient if sign(rs1)^sign(rs2), for DIV only.
  - Negate the remainder if sign(rs1), for REM only.
  - Special cases skip sign correction.
  - Select the output:
    - MUL: product low half.
    - MULH/MULHSU/MULHU: product high half.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Register into result, assert done for exactly one cycle, return to IDLE.
- Latency:
  - Normal ops: done is high after XLEN+2 rising edges counted from the edge sampling start (34 for XLEN=32).
  - Special cases: done is high after 2 edges.
- busy is high in CALC and FIN and low in IDLE. start while busy=1 is ignored, including operand changes.
- A new start may be sampled in the same cycle done is high, because the state is IDLE. That start is accepted.
- abort=1 in CALC or FIN:
  - Next state IDLE, busy=0, done stays 0, result unchanged.
  - abort in IDLE has no effect.
  - abort and start together in IDLE: abort wins, nothing is accepted.
- Reset asserted mid-operation: immediate return to reset values; no done afterwards.
- All arithmetic is modulo 2^XLEN (2^(2*XLEN) for the product). There are no exceptions or flags.

Decomposition:
- Shared package riscv_pkg:
  - XLEN default.
  - funct3 encodings for M-extension ops (localparam per op).
  - State encoding constants.
  - Special-case constants: all-ones, INT_MIN.
- No sub-module is required; a single datapath and FSM is natural.
- The sign-correction negate is a local function.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD: result=0xFFFFFFEB, done exactly 34 edges after start; busy high for the intervening cycles.
- MULH rs1=rs2=0x80000000: result=0x40000000. MULHU rs1=rs2=0xFFFFFFFF: result=0xFFFFFFFE. MULHSU rs1=0xFFFFFFFF, rs2=2: result=0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2: result=0xFFFFFFFD. REM same operands: result=0xFFFFFFFF. DIVU 100/7=14; REMU=2.
- Special cases, done after 2 edges:
  - DIVU rs1=5, rs2=0: result=0xFFFFFFFF.
  - REM rs1=5, rs2=0: result=5.
  - DIV 0x80000000 / 0xFFFFFFFF: result=0x80000000.
  - REM same operands: result=0.
- Abort at CALC iteration 10: busy=0 next edge, no done, result keeps its prior value. start with different operands while busy: ignored, original result returned.
- reset=0 at iteration 20: busy/done/result cleared asynchronously. Back-to-back start in the done cycle is accepted and completes correctly.
